// File: rtl/miss_refill_engine_pkg.sv
// Shared types and default widths for the miss refill engine and the cache that feeds it.
package miss_refill_engine_pkg;

  localparam int unsigned DefAddrW = 8;
  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefDepth = 2;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StFill
  } state_e;

  typedef struct packed {
    logic [DefAddrW-1:0] addr;
    logic                write;
    logic [DefDataW-1:0] wdata;
  } miss_entry_t;

  // Occupancy needs one extra bit so a full queue is distinguishable from empty.
  function automatic int unsigned cnt_width(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/miss_refill_engine_if.sv
// Miss, memory and fill signal bundle between the cache (master) and the refill engine (slave).
interface miss_refill_engine_if
  import miss_refill_engine_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth
);
  localparam int unsigned CntW = cnt_width(DEPTH);

  logic              miss_valid;
  logic              miss_ready;
  logic [ADDR_W-1:0] miss_addr;
  logic              miss_write;
  logic [DATA_W-1:0] miss_wdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  logic              fill_valid;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_data;
  logic              fill_write;
  logic [CntW-1:0]   outstanding;

  modport slave (
    input  miss_valid, miss_addr, miss_write, miss_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output miss_ready, mem_req, mem_we, mem_addr, mem_wdata,
    output fill_valid, fill_addr, fill_data, fill_write, outstanding
  );

  modport master (
    output miss_valid, miss_addr, miss_write, miss_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  miss_ready, mem_req, mem_we, mem_addr, mem_wdata,
    input  fill_valid, fill_addr, fill_data, fill_write, outstanding
  );

endinterface

// File: rtl/miss_refill_engine_fifo.sv
// In-order miss queue: circular buffer with wrapping pointers, occupancy count and
// a combinational head read.
module miss_fifo
  import miss_refill_engine_pkg::*;
#(
  parameter int unsigned DEPTH   = DefDepth,
  parameter type         entry_t = miss_entry_t,
  localparam int unsigned PtrW   = $clog2(DEPTH),
  localparam int unsigned CntW   = PtrW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  entry_t          push_data_i,
  input  logic            pop_i,
  output entry_t          head_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    // Simultaneous push and pop leaves occupancy unchanged.
    if (push_i && !pop_i) begin
      count_d = count_q + CntW'(1);
    end else if (!push_i && pop_i) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/miss_refill_engine.sv
// Queues cache misses and refills them one at a time from memory over req/gnt/rvalid,
// returning each completion to the cache as a single-cycle fill pulse.
module miss_refill_engine
  import miss_refill_engine_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth
) (
  input logic           clk,
  input logic           rst,
  miss_refill_engine_if.slave bus
);

  localparam int unsigned CntW = cnt_width(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [DATA_W-1:0] wdata;
  } entry_t;

  entry_t          push_entry;
  entry_t          head;
  entry_t          next_entry;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [CntW-1:0] count;

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              fill_valid_q, fill_valid_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic [DATA_W-1:0] fill_data_q, fill_data_d;
  logic              fill_write_q, fill_write_d;

  assign push_entry = '{addr: bus.miss_addr, write: bus.miss_write, wdata: bus.miss_wdata};
  assign push       = bus.miss_valid && bus.miss_ready;
  assign pop        = (state_q == StFill);

  miss_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (count)
  );

  // No bypass: a pop in the same cycle does not open a slot early.
  assign bus.miss_ready  = !full;
  assign bus.outstanding = count;

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.fill_valid = fill_valid_q;
  assign bus.fill_addr  = fill_addr_q;
  assign bus.fill_data  = fill_data_q;
  assign bus.fill_write = fill_write_q;

  // An empty queue being pushed this cycle issues straight from the incoming request.
  assign next_entry = empty ? push_entry : head;

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    fill_valid_d = 1'b0;
    fill_addr_d  = fill_addr_q;
    fill_data_d  = fill_data_q;
    fill_write_d = fill_write_q;
    case (state_q)
      StIdle: begin
        if (!empty || push) begin
          state_d     = StReq;
          mem_req_d   = 1'b1;
          mem_we_d    = next_entry.write;
          mem_addr_d  = next_entry.addr;
          mem_wdata_d = next_entry.wdata;
        end
      end
      StReq: begin
        if (bus.mem_gnt) begin
          state_d   = StWait;
          mem_req_d = 1'b0;
        end
      end
      StWait: begin
        if (bus.mem_rvalid) begin
          state_d      = StFill;
          fill_valid_d = 1'b1;
          fill_addr_d  = head.addr;
          fill_write_d = head.write;
          // Write misses fill with their own data; the memory response is only an ack.
          fill_data_d  = head.write ? head.wdata : bus.mem_rdata;
        end
      end
      StFill: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      fill_valid_q <= 1'b0;
      fill_addr_q  <= '0;
      fill_data_q  <= '0;
      fill_write_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      fill_valid_q <= fill_valid_d;
      fill_addr_q  <= fill_addr_d;
      fill_data_q  <= fill_data_d;
      fill_write_q <= fill_write_d;
    end
  end

endmodule
